// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the run/step/halt sequencer: FSM states, host
// command opcodes, halt cause codes and the EBREAK instruction word.
package exec_ctrl_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] cmd_op_t;
    typedef logic [2:0] halt_cause_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_CRST = 3'd2;
    localparam state_t ST_RUN  = 3'd3;
    localparam state_t ST_STEP = 3'd4;

    localparam cmd_op_t OP_RUN  = 2'b00;
    localparam cmd_op_t OP_STEP = 2'b01;
    localparam cmd_op_t OP_HALT = 2'b10;
    localparam cmd_op_t OP_LOAD = 2'b11;

    localparam halt_cause_t CAUSE_RESET     = 3'd0;
    localparam halt_cause_t CAUSE_HOST      = 3'd1;
    localparam halt_cause_t CAUSE_EBREAK    = 3'd2;
    localparam halt_cause_t CAUSE_BKPT      = 3'd3;
    localparam halt_cause_t CAUSE_STEP      = 3'd4;
    localparam halt_cause_t CAUSE_LOAD_DONE = 3'd5;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/imem_loader.sv
// Streams host program words into instruction memory. The word count is
// clamped to the memory depth, and a done pulse marks the final handshake.
module imem_loader
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [XLEN-1:0]    i_count,
    input  logic               i_active,
    input  logic               i_ld_valid,
    input  logic [XLEN-1:0]    i_ld_data,
    output logic               o_ld_ready,
    output logic               o_we,
    output logic [IMEM_AW-1:0] o_waddr,
    output logic [XLEN-1:0]    o_wdata,
    output logic               o_done
);

    localparam int DEPTH = 2 ** IMEM_AW;

    logic [IMEM_AW:0] r_count;
    logic [IMEM_AW:0] r_target;
    logic [IMEM_AW:0] w_clamp;

    // Requests longer than the memory are cut to its depth so the address never wraps.
    always_comb begin
        w_clamp = i_count[IMEM_AW:0];
        if (i_count > XLEN'(DEPTH)) begin
            w_clamp = (IMEM_AW+1)'(DEPTH);
        end
    end

    // Word counter restarts on each LOAD command and advances once per accepted word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count  <= '0;
            r_target <= '0;
        end else if (i_start) begin
            r_count  <= '0;
            r_target <= w_clamp;
        end else if (o_we) begin
            r_count <= r_count + (IMEM_AW+1)'(1);
        end
    end

    assign o_ld_ready = i_active;
    assign o_we       = i_active && i_ld_valid;
    assign o_waddr    = r_count[IMEM_AW-1:0];
    assign o_wdata    = i_ld_data;
    assign o_done     = o_we && (r_count == (r_target - (IMEM_AW+1)'(1)));

endmodule

// File: rtl/exec_ctrl.sv
// Run/step/halt sequencer for the single-cycle RV32 datapath. Owns the
// datapath clock enable and core reset, the step counter and the count of
// committed cycles, and hands program loading to imem_loader.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_op,
    input  logic [XLEN-1:0]    i_cmd_arg,
    input  logic               i_ld_valid,
    output logic               o_ld_ready,
    input  logic [XLEN-1:0]    i_ld_data,
    output logic               o_imem_we,
    output logic [IMEM_AW-1:0] o_imem_waddr,
    output logic [XLEN-1:0]    o_imem_wdata,
    output logic               o_core_en,
    output logic               o_core_rst,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [XLEN-1:0]    i_instruction,
    input  logic               i_bp_en,
    input  logic [XLEN-1:0]    i_bp_addr,
    output logic               o_halted,
    output logic [2:0]         o_halt_cause,
    output logic [XLEN-1:0]    o_retired
);

    state_t      r_state;
    state_t      w_next_state;
    halt_cause_t r_cause;
    halt_cause_t w_next_cause;
    logic [XLEN-1:0] r_step;
    logic [XLEN-1:0] r_retired;
    logic            r_first;

    logic w_idle;
    logic w_active;
    logic w_cmd_fire;
    logic w_ebreak;
    logic w_bkpt;
    logic w_host;
    logic w_stop;
    logic w_load_start;
    logic w_load_done;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_active = (r_state == ST_RUN) || (r_state == ST_STEP);

    // While executing only HALT is accepted; loading and core reset refuse commands.
    always_comb begin
        o_cmd_ready = 1'b0;
        if (w_idle) begin
            o_cmd_ready = 1'b1;
        end else if (w_active) begin
            o_cmd_ready = (i_cmd_op == OP_HALT);
        end
    end

    assign w_cmd_fire   = i_cmd_valid && o_cmd_ready;
    assign w_load_start = w_idle && w_cmd_fire && (i_cmd_op == OP_LOAD) && (i_cmd_arg != '0);

    // The breakpoint is ignored on the first executing cycle so a resume can leave it.
    assign w_ebreak = w_active && (i_instruction == XLEN'(EBREAK_INSN));
    assign w_bkpt   = w_active && i_bp_en && (i_pc == i_bp_addr) && !r_first;
    assign w_host   = w_active && w_cmd_fire && (i_cmd_op == OP_HALT);
    assign w_stop   = w_ebreak || w_bkpt || w_host;

    assign o_core_en    = w_active && !w_stop;
    assign o_core_rst   = i_reset || (r_state == ST_LOAD) || (r_state == ST_CRST);
    assign o_halted     = w_idle;
    assign o_halt_cause = r_cause;
    assign o_retired    = r_retired;

    imem_loader #(
        .XLEN    (XLEN),
        .IMEM_AW (IMEM_AW)
    ) u_loader (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_load_start),
        .i_count    (i_cmd_arg),
        .i_active   (r_state == ST_LOAD),
        .i_ld_valid (i_ld_valid),
        .i_ld_data  (i_ld_data),
        .o_ld_ready (o_ld_ready),
        .o_we       (o_imem_we),
        .o_waddr    (o_imem_waddr),
        .o_wdata    (o_imem_wdata),
        .o_done     (w_load_done)
    );

    // Next state and halt cause; stop reasons are ranked EBREAK, breakpoint, host, step.
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    case (i_cmd_op)
                        OP_RUN:  w_next_state = ST_RUN;
                        OP_STEP: w_next_state = ST_STEP;
                        OP_LOAD: w_next_state = (i_cmd_arg == '0) ? ST_CRST : ST_LOAD;
                        default: w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_load_done) begin
                    w_next_state = ST_CRST;
                end
            end
            ST_CRST: begin
                w_next_state = ST_IDLE;
                w_next_cause = CAUSE_LOAD_DONE;
            end
            ST_RUN, ST_STEP: begin
                if (w_ebreak) begin
                    w_next_state = ST_IDLE;
                    w_next_cause = CAUSE_EBREAK;
                end else if (w_bkpt) begin
                    w_next_state = ST_IDLE;
                    w_next_cause = CAUSE_BKPT;
                end else if (w_host) begin
                    w_next_state = ST_IDLE;
                    w_next_cause = CAUSE_HOST;
                end else if ((r_state == ST_STEP) && (r_step == XLEN'(1))) begin
                    w_next_state = ST_IDLE;
                    w_next_cause = CAUSE_STEP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, cause and first-cycle flag registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cause <= CAUSE_RESET;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cause <= w_next_cause;
            r_first <= w_idle && w_cmd_fire &&
                       ((i_cmd_op == OP_RUN) || (i_cmd_op == OP_STEP));
        end
    end

    // Step budget loads on STEP (zero means one) and counts down per committed cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_step <= '0;
        end else if (w_idle && w_cmd_fire && (i_cmd_op == OP_STEP)) begin
            r_step <= (i_cmd_arg == '0) ? XLEN'(1) : i_cmd_arg;
        end else if ((r_state == ST_STEP) && o_core_en) begin
            r_step <= r_step - XLEN'(1);
        end
    end

    // Committed-cycle counter, cleared when a new program load is accepted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_retired <= '0;
        end else if (w_idle && w_cmd_fire && (i_cmd_op == OP_LOAD)) begin
            r_retired <= '0;
        end else if (o_core_en) begin
            r_retired <= r_retired + XLEN'(1);
        end
    end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
Run/step/halt sequencer for the single-cycle RV32 datapath.
- Gates datapath state updates (PC, register file, data memory) through a single clock enable.
- Streams program words into instruction memory, then applies a one-cycle core reset.
- Stops execution on EBREAK, a PC breakpoint, step-count exhaustion or a host HALT command.
- Sits between the host/debug interface (UART bridge or switches) and the datapath top.

Parameters:
- XLEN, 32, datapath word width (PC, instruction, cmd_arg, load data, counters).
- IMEM_AW, 6, instruction-memory word-address width; depth = 2**IMEM_AW words.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 RUN, 01 STEP, 10 HALT, 11 LOAD.
- cmd_arg  in  XLEN  STEP: instruction count; LOAD: word count; otherwise ignored.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted when ld_valid && ld_ready.
- ld_data  in  XLEN  program word.
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  IMEM_AW  instruction-memory word address.
- imem_wdata  out  XLEN  instruction-memory write data.
- core_en  out  1  datapath update enable for the current cycle.
- core_rst  out  1  datapath reset (PC, register file).
- pc  in  XLEN  current datapath PC.
- instruction  in  XLEN  current fetched instruction.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  XLEN  breakpoint PC.
- halted  out  1  high in IDLE.
- halt_cause  out  3  0 RESET, 1 HOST, 2 EBREAK, 3 BKPT, 4 STEP, 5 LOAD_DONE.
- retired  out  XLEN  count of enabled (committed) cycles.

Behaviour:
- States: IDLE, LOAD, CRST, RUN, STEP. Reset state is IDLE.
- Reset values: halted=1, halt_cause=0, retired=0, core_en=0, ld_ready=0, imem_we=0. core_rst=1 while reset is asserted.
- cmd_ready:
  - 1 in IDLE for any op.
  - 1 in RUN/STEP only when cmd_op==HALT.
  - 0 in LOAD and CRST.
  - HALT accepted in IDLE is a no-op.
- IDLE transitions:
  - RUN → RUN.
  - STEP → STEP; step counter loads cmd_arg, with 0 treated as 1.
  - LOAD → LOAD; word counter cleared; target = min(cmd_arg, 2**IMEM_AW); retired cleared.
  - LOAD with cmd_arg=0 goes directly to CRST.
- LOAD:
  - ld_ready=1, core_rst=1.
  - imem_we = ld_valid && ld_ready (combinational), imem_waddr = word counter, imem_wdata = ld_data.
  - Counter increments on each handshake; after the handshake of word target-1, next state is CRST.
  - Extra words beyond target are not accepted (ld_ready=0 outside LOAD).
- CRST: core_rst=1 for exactly one cycle, then IDLE with halt_cause=LOAD_DONE.
- RUN/STEP stop conditions, evaluated combinationally on the current pc/instruction. Priority: EBREAK > BKPT > HOST > STEP.
  - EBREAK: instruction==32'h00100073.
  - BKPT: bp_en && pc==bp_addr. Suppressed on the first cycle after entering RUN/STEP so that resuming from a breakpoint makes progress.
  - HOST: HALT handshake in this cycle.
- On EBREAK, BKPT or HOST: core_en=0 in that cycle (instruction not committed), next state IDLE, halt_cause latched.
- Otherwise core_en=1 and retired increments (wraps modulo 2**XLEN).
- STEP: the counter decrements on each enabled cycle. The enabled cycle with counter==1 commits that instruction, then goes to IDLE with cause STEP.
- Reset asserted mid-operation: immediate return to IDLE, all registers at reset values. A partial LOAD is abandoned and already-written words remain in memory.
- core_en is never 1 in IDLE, LOAD or CRST.

Decomposition:
- Shared package exec_ctrl_pkg:
  - state encoding.
  - cmd_op codes.
  - halt_cause codes.
  - EBREAK encoding constant.
- One sub-module, imem_loader: word counter, target clamp, write strobe/address generation and done pulse.
- The FSM, step counter and retired counter stay in exec_ctrl.

Test Plan:
- Reset, then LOAD cmd_arg=3 with words A,B,C → imem writes at addresses 0,1,2; core_rst high through CRST; then halted=1, halt_cause=5.
- STEP cmd_arg=2 from IDLE → core_en high for exactly 2 cycles; retired=2; halt_cause=4.
- RUN with EBREAK at pc=0x8 (straight-line code) → core_en=0 in the EBREAK cycle; retired=2; halt_cause=2.
- bp_en=1, bp_addr=0x4, RUN → halts with pc=0x4, cause 3. Second RUN → executes 0x4 (no re-hit on first cycle) and continues.
- RUN, then HALT on the same cycle as instruction==EBREAK → halt_cause=2 (EBREAK wins).
- LOAD cmd_arg=100 with IMEM_AW=6 → exactly 64 words accepted, last address 63. Reset asserted after word 10 → IDLE, halt_cause=0, retired=0.
